hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core; it sits beside the forwarding unit and covers what forwarding cannot resolve. It detects load-use hazards, flushes on taken branches and freezes the pipe while data memory is busy. It drives the stage-register write enables and bubble/flush controls, and flags a sticky timeout when memory never answers.

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline load-use/branch/memory-wait sequencing controller
// Optional HAZARD_PERF_EN adds stall/flush/load-use event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_Rs1,
  input  logic [4:0]  IF_ID_Rs2,
  input  logic        IF_ID_UseRs1,
  input  logic        IF_ID_UseRs2,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        ID_EX_MemRead,
  input  logic        EX_BranchTaken,
  input  logic        MEM_Req,
  input  logic        MEM_Ready,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MEM_WB_Bubble,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] load_use_count,
`endif
  output logic        mem_timeout
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;
  logic       r_mem_timeout;
  logic       w_mem_busy;
  logic       w_load_use;
  logic       w_branch_act;
  logic       w_load_use_act;

  assign w_mem_busy = MEM_Req && !MEM_Ready;

  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((IF_ID_UseRs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                       (IF_ID_UseRs2 && (ID_EX_Rd == IF_ID_Rs2)));

  assign w_branch_act   = !w_mem_busy && EX_BranchTaken;
  assign w_load_use_act = !w_mem_busy && !EX_BranchTaken && w_load_use;

  // Saturating wait counter; the stall itself is never released by timeout.
  assign w_wait_cnt_next = !w_mem_busy ? 8'd0 :
                           (r_wait_cnt == TIMEOUT_VAL) ? r_wait_cnt :
                           r_wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_mem_busy && (w_wait_cnt_next == TIMEOUT_VAL)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // Completion in MEM_WAIT falls through to the normal priority chain.
  always_comb begin
    w_state_next  = r_state;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    MEM_WB_Bubble = 1'b0;
    case (r_state)
      RUN, MEM_WAIT: begin
        w_state_next = w_mem_busy ? MEM_WAIT : RUN;
        if (w_mem_busy) begin
          PC_Write      = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Write  = 1'b0;
          MEM_WB_Bubble = 1'b1;
        end else if (EX_BranchTaken) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
        end else if (w_load_use) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;
  logic [31:0] r_load_use_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles   <= 32'd0;
      r_flush_count    <= 32'd0;
      r_load_use_count <= 32'd0;
    end else begin
      if (w_mem_busy)     r_stall_cycles   <= r_stall_cycles + 32'd1;
      if (w_branch_act)   r_flush_count    <= r_flush_count + 32'd1;
      if (w_load_use_act) r_load_use_count <= r_load_use_count + 32'd1;
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign flush_count    = r_flush_count;
  assign load_use_count = r_load_use_count;
`else
  logic w_unused;
  assign w_unused = w_branch_act ^ w_load_use_act;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam logic [6:0] C_NORM = 7'b1111000;
  localparam logic [6:0] C_LU   = 7'b0011010;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_BUSY = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic       IF_ID_UseRs1, IF_ID_UseRs2, ID_EX_MemRead;
  logic       EX_BranchTaken, MEM_Req, MEM_Ready;
  logic       PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic       IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count, load_use_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .IF_ID_UseRs1(IF_ID_UseRs1), .IF_ID_UseRs2(IF_ID_UseRs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .MEM_WB_Bubble(MEM_WB_Bubble),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .load_use_count(load_use_count),
`endif
    .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl();
    return {25'd0, PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
            IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble};
  endfunction

  task automatic idle();
    IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0; IF_ID_UseRs1 = 1'b0; IF_ID_UseRs2 = 1'b0;
    ID_EX_Rd = 5'd0; ID_EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    MEM_Req = 1'b0; MEM_Ready = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    ID_EX_MemRead = 1'b1; ID_EX_Rd = rd;
    IF_ID_Rs1 = rs1; IF_ID_UseRs1 = u1; IF_ID_Rs2 = rs2; IF_ID_UseRs2 = u2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    #1;
    check(tag, ctrl(), {25'd0, exp});
  endtask

  task automatic chk_regs(input string tag, input logic st, input logic [7:0] cnt, input logic to);
    check({tag, "_state"}, {31'd0, dut.r_state}, {31'd0, st});
    check({tag, "_cnt"}, {24'd0, dut.r_wait_cnt}, {24'd0, cnt});
    check({tag, "_tmo"}, {31'd0, mem_timeout}, {31'd0, to});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    chk_ctrl("rst_ctrl", C_NORM);
    tick(); tick();
    rst = 1'b0;
    chk_regs("rst", 1'b0, 8'd0, 1'b0);

    load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    chk_ctrl("lu_rs1", C_LU);
    tick();
    idle();
    chk_ctrl("lu_after", C_NORM);
    load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    chk_ctrl("lu_rd0", C_NORM);
    load_use(5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    chk_ctrl("lu_nouse", C_NORM);
    load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    chk_ctrl("lu_rs2", C_LU);
    ID_EX_MemRead = 1'b0;
    chk_ctrl("lu_noload", C_NORM);
    load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    EX_BranchTaken = 1'b1;
    chk_ctrl("br_lu", C_BR);
    tick();

    idle();
    MEM_Req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk_ctrl($sformatf("wait3_%0d", i), C_BUSY);
      tick();
      chk_regs($sformatf("wait3_%0d", i), 1'b1, 8'(i), 1'b0);
    end
    MEM_Ready = 1'b1;
    chk_ctrl("wait3_done", C_NORM);
    tick();
    chk_regs("wait3_done", 1'b0, 8'd0, 1'b0);

    idle();
    EX_BranchTaken = 1'b1; MEM_Req = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      chk_ctrl($sformatf("wbr_%0d", i), C_BUSY);
      tick();
    end
    MEM_Ready = 1'b1;
    chk_ctrl("wbr_release", C_BR);
    tick();

    idle();
    load_use(5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
    MEM_Req = 1'b1;
    chk_ctrl("wlu_busy", C_BUSY);
    tick();
    MEM_Ready = 1'b1;
    chk_ctrl("wlu_release", C_LU);
    tick();

    idle();
    MEM_Ready = 1'b1;
    chk_ctrl("ready_noreq", C_NORM);
    tick();
    chk_regs("ready_noreq", 1'b0, 8'd0, 1'b0);

    MEM_Ready = 1'b0; MEM_Req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_regs($sformatf("tmo_%0d", i), 1'b1, 8'(i), 1'b0);
    end
    tick();
    chk_regs("tmo_4", 1'b1, 8'd4, 1'b1);
    chk_ctrl("tmo_still_stalled", C_BUSY);
    tick();
    chk_regs("tmo_sat", 1'b1, 8'd4, 1'b1);
    MEM_Ready = 1'b1;
    tick();
    chk_regs("tmo_sticky", 1'b0, 8'd0, 1'b1);
    idle();
    tick();
    chk_regs("tmo_idle", 1'b0, 8'd0, 1'b1);

    MEM_Req = 1'b1;
    tick();
    chk_regs("rmw_1", 1'b1, 8'd1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk_regs("rmw_after", 1'b0, 8'd0, 1'b0);
    chk_ctrl("rmw_ctrl", C_NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
